// File: rtl/cordic_trig_sched.sv
// -----------------------------------------------------------------------------
// cordic_trig_sched
//
// Shares one CORDIC rotation core and its quadrant sign handler among N_REQ
// requesters asking for sin or cos of a signed Q16.16 angle. A request is
// granted round-robin, its angle is folded into the first quadrant, the core
// is launched and watched with a timeout, the sign handler is given the
// quadrant/sign/mode, and the signed result goes back to the requester.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   req           per-requester request level, held until its rsp_valid
//   req_angle     packed signed Q16.16 angles, slice i = [32i+31:32i]
//   req_mode      per-requester mode, 0 = cos, 1 = sin
//   rsp_valid     one-cycle response pulse to the served requester
//   rsp_data      signed Q16.16 result (0 on error)
//   rsp_err       out-of-range angle or core timeout
//   busy          high whenever the scheduler is not idle
//   core_start    one-cycle start pulse to the CORDIC core
//   core_angle    reduced angle in [0, PI/2]
//   core_done     core completion level
//   sh_kuadran    quadrant for the sign handler
//   sh_isneg      sign of the original angle
//   sh_mode       latched mode of the granted request
//   sh_done       level done to the sign handler (it edge-detects this)
//   sh_valid      sign handler one-cycle result pulse
//   sh_result     sign-adjusted result from the sign handler
// -----------------------------------------------------------------------------
module cordic_trig_sched #(
   parameter int N_REQ       = 4,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req,
   input  logic [32*N_REQ-1:0]  req_angle,
   input  logic [N_REQ-1:0]     req_mode,
   output logic [N_REQ-1:0]     rsp_valid,
   output logic [31:0]          rsp_data,
   output logic                 rsp_err,
   output logic                 busy,
   output logic                 core_start,
   output logic [31:0]          core_angle,
   input  logic                 core_done,
   output logic [1:0]           sh_kuadran,
   output logic                 sh_isneg,
   output logic                 sh_mode,
   output logic                 sh_done,
   input  logic                 sh_valid,
   input  logic [31:0]          sh_result
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   localparam logic signed [32:0] PI_2   = 33'sd102944;
   localparam logic signed [32:0] PI     = 33'sd205887;
   localparam logic signed [32:0] PI3_2  = 33'sd308831;
   localparam logic signed [32:0] TWO_PI = 33'sd411775;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      WAIT_CORE,
      SIGN,
      RESP
   } state_t;

   state_t             state;
   logic [IDX_W-1:0]   last;
   logic [IDX_W-1:0]   grant;
   logic [31:0]        angle_q;
   logic [CNT_W-1:0]   tmo_cnt;

   logic               found;
   logic [IDX_W-1:0]   pick;
   logic [IDX_W-1:0]   cand;
   logic [31:0]        sel_angle;

   logic signed [32:0] ang_ext;
   logic signed [32:0] ang_abs;
   logic [31:0]        r_red;
   logic [1:0]         q_red;
   logic               oor;

   // Round-robin arbiter: scan upward from the requester after the last one
   // served, wrapping, and take the first active request bit.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = IDX_W'((int'(last) + k) % N_REQ);
         if (!found && req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   // Pull the winning requester's angle out of the packed angle bus.
   always_comb begin
      sel_angle = req_angle[31:0];
      for (int i = 0; i < N_REQ; i++) begin
         if (pick == IDX_W'(i)) begin
            sel_angle = req_angle[32*i +: 32];
         end
      end
   end

   // Range reduction of the latched angle. The magnitude is taken in 33 bits
   // so that the most negative Q16.16 value still has a representable
   // absolute value (and is then rejected as out of range).
   always_comb begin
      ang_ext = {angle_q[31], angle_q};
      ang_abs = ang_ext[32] ? -ang_ext : ang_ext;
      oor     = 1'b0;
      q_red   = 2'd0;
      r_red   = 32'(ang_abs);
      if (ang_abs >= TWO_PI) begin
         oor = 1'b1;
      end else if (ang_abs < PI_2) begin
         q_red = 2'd0;
         r_red = 32'(ang_abs);
      end else if (ang_abs < PI) begin
         q_red = 2'd1;
         r_red = 32'(PI - ang_abs);
      end else if (ang_abs < PI3_2) begin
         q_red = 2'd2;
         r_red = 32'(ang_abs - PI);
      end else begin
         q_red = 2'd3;
         r_red = 32'(TWO_PI - ang_abs);
      end
   end

   // Main scheduler FSM. Every output is a flop updated on the transition
   // into the state in which it must be visible, so core_start, sh_done and
   // rsp_valid line up exactly with START, SIGN and RESP. core_done is only
   // looked at in WAIT_CORE, which is what makes a level left over from the
   // previous operation harmless: the core clears it on our start pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last       <= IDX_W'(N_REQ - 1);
         grant      <= '0;
         angle_q    <= '0;
         tmo_cnt    <= '0;
         rsp_valid  <= '0;
         rsp_data   <= '0;
         rsp_err    <= 1'b0;
         busy       <= 1'b0;
         core_start <= 1'b0;
         core_angle <= '0;
         sh_kuadran <= 2'd0;
         sh_isneg   <= 1'b0;
         sh_mode    <= 1'b0;
         sh_done    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  grant   <= pick;
                  angle_q <= sel_angle;
                  sh_mode <= req_mode[pick];
                  busy    <= 1'b1;
                  state   <= LOAD;
               end
            end
            LOAD: begin
               if (oor) begin
                  rsp_valid <= N_REQ'(1) << grant;
                  rsp_data  <= '0;
                  rsp_err   <= 1'b1;
                  state     <= RESP;
               end else begin
                  core_angle <= r_red;
                  sh_kuadran <= q_red;
                  sh_isneg   <= angle_q[31];
                  core_start <= 1'b1;
                  state      <= START;
               end
            end
            START: begin
               core_start <= 1'b0;
               tmo_cnt    <= '0;
               state      <= WAIT_CORE;
            end
            WAIT_CORE: begin
               if (core_done) begin
                  sh_done <= 1'b1;
                  state   <= SIGN;
               end else if (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                  rsp_valid <= N_REQ'(1) << grant;
                  rsp_data  <= '0;
                  rsp_err   <= 1'b1;
                  state     <= RESP;
               end else begin
                  tmo_cnt <= tmo_cnt + CNT_W'(1);
               end
            end
            SIGN: begin
               if (sh_valid) begin
                  sh_done   <= 1'b0;
                  rsp_valid <= N_REQ'(1) << grant;
                  rsp_data  <= sh_result;
                  rsp_err   <= 1'b0;
                  state     <= RESP;
               end
            end
            RESP: begin
               rsp_valid <= '0;
               rsp_data  <= '0;
               rsp_err   <= 1'b0;
               busy      <= 1'b0;
               last      <= grant;
               state     <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
